icache_fetch_port: RTL and testbench



---
 rtl/icache_pkg.sv | 20 ++
 rtl/icache_fetch_port_if.sv | 27 ++
 rtl/icache_line_array.sv | 66 ++++++
 rtl/icache_fetch_port.sv | 180 ++++++++++++++++++
 tb/tb_icache_fetch_port.sv | 217 +++++++++++++++++++++
 5 files changed

// File: rtl/icache_pkg.sv
// rtl/icache_pkg.sv - shared widths, FSM state type and line-base helper for the fetch-port icache
package icache_pkg;

    localparam int INDEX_W  = 4;
    localparam int OFFSET_W = 4;
    localparam int TAG_W    = 32 - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOOKUP,
        ST_REFILL,
        ST_RESP
    } state_t;

    // Byte address of the first byte of the line holding a.
    function automatic logic [31:0] line_base(input logic [31:0] a, input int unsigned ow);
        return a & ~((32'd1 << ow) - 32'd1);
    endfunction

endpackage

// File: rtl/icache_fetch_port_if.sv
// rtl/icache_fetch_port_if.sv - fetch request/response and byte-wide memory bus bundle
// slave  : the cache (takes fetch requests, drives the memory request side)
// master : fetch stage + memory (drives requests, flush, grant and read bytes)
interface icache_fetch_port_if;

    logic        flush;
    logic        asking;
    logic [31:0] addr;
    logic [31:0] data;
    logic        data_ready;
    logic        busy;
    logic        mem_req;
    logic [31:0] mem_a;
    logic        mem_grant;
    logic [7:0]  mem_din;

    modport slave (
        input  flush, asking, addr, mem_grant, mem_din,
        output data, data_ready, busy, mem_req, mem_a
    );

    modport master (
        output flush, asking, addr, mem_grant, mem_din,
        input  data, data_ready, busy, mem_req, mem_a
    );

endinterface

// File: rtl/icache_line_array.sv
// rtl/icache_line_array.sv - valid/tag/data storage, one byte write port, two line read ports
// Ports: clr_* clears a valid bit, wr_* writes one data byte, set_* loads tag and sets valid,
//        rd_a_* / rd_b_* return valid, tag and the whole line combinationally.
module icache_line_array #(
    parameter int INDEX_W  = 4,
    parameter int OFFSET_W = 4
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             clr_en,
    input  logic [INDEX_W-1:0]               clr_idx,
    input  logic                             wr_en,
    input  logic [INDEX_W-1:0]               wr_idx,
    input  logic [OFFSET_W-1:0]              wr_off,
    input  logic [7:0]                       wr_byte,
    input  logic                             set_en,
    input  logic [INDEX_W-1:0]               set_idx,
    input  logic [32-INDEX_W-OFFSET_W-1:0]   set_tag,
    input  logic [INDEX_W-1:0]               rd_a_idx,
    output logic                             rd_a_valid,
    output logic [32-INDEX_W-OFFSET_W-1:0]   rd_a_tag,
    output logic [(8<<OFFSET_W)-1:0]         rd_a_line,
    input  logic [INDEX_W-1:0]               rd_b_idx,
    output logic                             rd_b_valid,
    output logic [32-INDEX_W-OFFSET_W-1:0]   rd_b_tag,
    output logic [(8<<OFFSET_W)-1:0]         rd_b_line
);

    localparam int TAG_W      = 32 - INDEX_W - OFFSET_W;
    localparam int LINES      = 1 << INDEX_W;
    localparam int LINE_BYTES = 1 << OFFSET_W;

    logic [LINES-1:0] valid;
    logic [TAG_W-1:0] tags  [LINES];
    logic [7:0]       bytes [LINES][LINE_BYTES];

    // Only the valid bits need a reset; tags and data are qualified by them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= '0;
        end else begin
            if (clr_en) valid[clr_idx] <= 1'b0;
            if (set_en) valid[set_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (set_en) tags[set_idx] <= set_tag;
        if (wr_en)  bytes[wr_idx][wr_off] <= wr_byte;
    end

    always_comb begin
        rd_a_line = '0;
        rd_b_line = '0;
        for (int i = 0; i < LINE_BYTES; i++) begin
            rd_a_line[i*8 +: 8] = bytes[rd_a_idx][i];
            rd_b_line[i*8 +: 8] = bytes[rd_b_idx][i];
        end
    end

    assign rd_a_valid = valid[rd_a_idx];
    assign rd_a_tag   = tags[rd_a_idx];
    assign rd_b_valid = valid[rd_b_idx];
    assign rd_b_tag   = tags[rd_b_idx];

endmodule

// File: rtl/icache_fetch_port.sv
// rtl/icache_fetch_port.sv - direct-mapped icache serving halfword-aligned 32-bit fetches
// Ports: clk, rst_n (async, active-low); bus (slave) carries flush/asking/addr in,
//        data/data_ready/busy out, and the byte-wide mem_req/mem_a/mem_grant/mem_din refill bus.
module icache_fetch_port #(
    parameter int INDEX_W  = icache_pkg::INDEX_W,
    parameter int OFFSET_W = icache_pkg::OFFSET_W
) (
    input  logic               clk,
    input  logic               rst_n,
    icache_fetch_port_if.slave bus
);
    import icache_pkg::*;

    localparam int TAG_W     = 32 - INDEX_W - OFFSET_W;
    localparam int LINE_BITS = 8 << OFFSET_W;

    state_t              state, next_state;
    logic [31:0]         req_addr;
    logic [INDEX_W-1:0]  tgt_idx;
    logic [TAG_W-1:0]    tgt_tag;
    logic [OFFSET_W-1:0] k;
    logic [OFFSET_W-1:0] wr_off;
    logic                all_req;
    logic                wr_pend;
    logic [31:0]         data_q;
    logic                data_ready_q;

    logic [31:0]          b_addr;
    logic [OFFSET_W-1:0]  off;
    logic [INDEX_W-1:0]   idx_a, idx_b, miss_idx;
    logic [TAG_W-1:0]     tag_a, tag_b, miss_tag;
    logic                 valid_a, valid_b;
    logic [TAG_W-1:0]     ltag_a, ltag_b;
    logic [LINE_BITS-1:0] line_a, line_b;
    logic [2*LINE_BITS-1:0] window;
    logic [31:0]          assembled;
    logic                 need_b, hit_a, hit_b, hit;
    logic                 busy, mem_req, clr_en, wr_en, set_en, grant_ok;
    logic [31:0]          mem_a;

    // Line B is the line holding the last byte of the word (modular, so 0xFFFF_FFFE wraps to line 0).
    assign b_addr   = req_addr + 32'd3;
    assign off      = req_addr[OFFSET_W-1:0];
    assign idx_a    = req_addr[OFFSET_W +: INDEX_W];
    assign tag_a    = req_addr[31 -: TAG_W];
    assign idx_b    = b_addr[OFFSET_W +: INDEX_W];
    assign tag_b    = b_addr[31 -: TAG_W];
    assign need_b   = off > OFFSET_W'((1 << OFFSET_W) - 4);
    assign hit_a    = valid_a && (ltag_a == tag_a);
    assign hit_b    = valid_b && (ltag_b == tag_b);
    assign hit      = hit_a && (!need_b || hit_b);
    assign miss_idx = hit_a ? idx_b : idx_a;
    assign miss_tag = hit_a ? tag_b : tag_a;

    // Low bytes from A starting at the offset, spilling into B from its byte 0.
    always_comb begin
        window    = {line_b, line_a} >> {off, 3'b000};
        assembled = window[31:0];
    end

    assign grant_ok = mem_req && bus.mem_grant;
    // The byte granted last cycle lands now, unless a flush discards it.
    assign wr_en    = (state == ST_REFILL) && wr_pend && !bus.flush;
    assign set_en   = wr_en && (wr_off == '1);

    icache_line_array #(.INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W)) u_lines (
        .clk        (clk),
        .rst_n      (rst_n),
        .clr_en     (clr_en),
        .clr_idx    (miss_idx),
        .wr_en      (wr_en),
        .wr_idx     (tgt_idx),
        .wr_off     (wr_off),
        .wr_byte    (bus.mem_din),
        .set_en     (set_en),
        .set_idx    (tgt_idx),
        .set_tag    (tgt_tag),
        .rd_a_idx   (idx_a),
        .rd_a_valid (valid_a),
        .rd_a_tag   (ltag_a),
        .rd_a_line  (line_a),
        .rd_b_idx   (idx_b),
        .rd_b_valid (valid_b),
        .rd_b_tag   (ltag_b),
        .rd_b_line  (line_b)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= ST_IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (bus.asking) next_state = ST_LOOKUP;
            ST_LOOKUP: next_state = hit ? ST_RESP : ST_REFILL;
            ST_REFILL: if (set_en) next_state = ST_LOOKUP;
            ST_RESP:   next_state = ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
        if (bus.flush) next_state = ST_IDLE;
    end

    // A miss issues byte 0 from LOOKUP itself, so a refill costs exactly 16 request cycles
    // plus the trailing data-return cycle on top of the hit path.
    always_comb begin
        busy    = (state != ST_IDLE);
        mem_req = 1'b0;
        mem_a   = '0;
        clr_en  = 1'b0;
        case (state)
            ST_LOOKUP: if (!hit) begin
                mem_req = !bus.flush;
                mem_a   = line_base(hit_a ? b_addr : req_addr, OFFSET_W);
                clr_en  = !bus.flush;
            end
            ST_REFILL: begin
                mem_req = !bus.flush && !all_req;
                mem_a   = {tgt_tag, tgt_idx, k};
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_addr     <= '0;
            tgt_idx      <= '0;
            tgt_tag      <= '0;
            k            <= '0;
            wr_off       <= '0;
            all_req      <= 1'b0;
            wr_pend      <= 1'b0;
            data_q       <= '0;
            data_ready_q <= 1'b0;
        end else begin
            data_ready_q <= 1'b0;
            if (bus.flush) begin
                wr_pend <= 1'b0;
                all_req <= 1'b0;
            end else begin
                case (state)
                    ST_IDLE: if (bus.asking) req_addr <= bus.addr & ~32'd1;
                    ST_LOOKUP: if (!hit) begin
                        tgt_idx <= miss_idx;
                        tgt_tag <= miss_tag;
                        all_req <= 1'b0;
                        wr_off  <= '0;
                        wr_pend <= grant_ok;
                        k       <= grant_ok ? OFFSET_W'(1) : '0;
                    end
                    ST_REFILL: begin
                        wr_pend <= grant_ok;
                        if (grant_ok) begin
                            wr_off <= k;
                            k      <= k + 1'b1;
                            if (k == '1) all_req <= 1'b1;
                        end
                    end
                    ST_RESP: begin
                        data_q       <= assembled;
                        data_ready_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign bus.busy       = busy;
    assign bus.mem_req    = mem_req;
    assign bus.mem_a      = mem_a;
    assign bus.data       = data_q;
    assign bus.data_ready = data_ready_q;

    // Fetch must not request while a previous request is outstanding.
    asking_while_busy: assert property (@(posedge clk) disable iff (!rst_n) !(bus.asking && busy));

endmodule

// File: tb/tb_icache_fetch_port.sv
// tb/tb_icache_fetch_port.sv - scoreboard bench for icache_fetch_port
module tb_icache_fetch_port;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    icache_fetch_port_if bus();

    icache_fetch_port dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int ask_cyc = 0;
    int resp_seen = 0;
    int gcount = 0;
    logic grant_toggle = 1'b0;
    logic grant_ph = 1'b0;

    logic [31:0] exp_q[$];
    int          lat_q[$];
    logic [31:0] addr_q[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] mem_byte(input logic [31:0] a);
        logic [7:0] r;
        r = a[7:0] * 8'd13 + a[31:24] + 8'h29;
        return r;
    endfunction

    function automatic logic [31:0] exp_word(input logic [31:0] a);
        return {mem_byte(a + 32'd3), mem_byte(a + 32'd2), mem_byte(a + 32'd1), mem_byte(a)};
    endfunction

    always @(posedge clk) begin
        cyc      <= cyc + 1;
        grant_ph <= ~grant_ph;
    end

    assign bus.mem_grant = grant_toggle ? grant_ph : 1'b1;

    // Memory responder: byte appears the cycle after its grant.
    always @(posedge clk) begin
        if (rst_n && bus.mem_req && bus.mem_grant) begin
            bus.mem_din <= mem_byte(bus.mem_a);
            addr_q.push_back(bus.mem_a);
            gcount++;
        end
    end

    // Scoreboard: every data_ready pops one expected word and latency.
    always @(negedge clk) begin
        if (rst_n && bus.data_ready) begin
            if (exp_q.size() == 0) begin
                check_eq("unexpected_ready", 32'(bus.data_ready), 32'd0);
            end else begin
                check_eq("data", bus.data, exp_q.pop_front());
                check_eq("latency", 32'(cyc - ask_cyc), 32'(lat_q.pop_front()));
            end
            resp_seen++;
        end
    end

    task automatic issue(input logic [31:0] a);
        @(negedge clk);
        bus.asking = 1'b1;
        bus.addr   = a;
        @(negedge clk);
        bus.asking = 1'b0;
        ask_cyc    = cyc;
        check_eq("busy_after_accept", 32'(bus.busy), 32'd1);
    endtask

    task automatic wait_resp(input int budget);
        int seen0;
        bit got;
        seen0 = resp_seen;
        got = 1'b0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (resp_seen > seen0) got = 1'b1;
        end
        if (!got) check_eq("resp_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    task automatic fetch(input logic [31:0] a, input int lat);
        exp_q.push_back(exp_word(a));
        addr_q.delete();
        issue(a);
        if (grant_toggle) lat_q.push_back(19 + (grant_ph ? 15 : 16));
        else              lat_q.push_back(lat);
        wait_resp(200);
    endtask

    task automatic check_addrs(input logic [31:0] base, input int n);
        check_eq("addr_count", 32'(addr_q.size()), 32'(n));
        for (int i = 0; i < n && i < addr_q.size(); i++)
            check_eq("mem_a_order", addr_q[i], base + 32'(i));
    endtask

    task automatic wait_grants(input int n);
        for (int i = 0; i < 100 && gcount < n; i++) @(negedge clk);
        check_eq("grants_reached", 32'(gcount), 32'(n));
    endtask

    task automatic check_outputs_zero(input string tag);
        check_eq({tag, "_data"},       bus.data,              32'd0);
        check_eq({tag, "_data_ready"}, 32'(bus.data_ready),   32'd0);
        check_eq({tag, "_busy"},       32'(bus.busy),         32'd0);
        check_eq({tag, "_mem_req"},    32'(bus.mem_req),      32'd0);
        check_eq({tag, "_mem_a"},      bus.mem_a,             32'd0);
    endtask

    initial begin
        int seen0;
        bus.flush   = 1'b0;
        bus.asking  = 1'b0;
        bus.addr    = '0;
        bus.mem_din = '0;
        repeat (3) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Cold miss, then hit in the same line.
        fetch(32'h0000_0000, 19);
        check_addrs(32'h0000_0000, 16);
        fetch(32'h0000_0004, 2);
        check_addrs(32'h0, 0);
        repeat (3) @(negedge clk);
        check_eq("data_hold", bus.data, exp_word(32'h0000_0004));

        // Straddle with line 1 cached, line 2 cold.
        fetch(32'h0000_0010, 19);
        fetch(32'h0000_001E, 19);
        check_addrs(32'h0000_0020, 16);

        // Both lines cold: two back-to-back refills.
        fetch(32'h0000_003E, 36);
        check_addrs(32'h0000_0030, 32);

        // Wrap into line 0, which is already cached.
        fetch(32'hFFFF_FFFE, 19);
        check_addrs(32'hFFFF_FFF0, 16);

        // Alternating grant.
        grant_toggle = 1'b1;
        fetch(32'h0000_0056, 0);
        check_addrs(32'h0000_0050, 16);
        grant_toggle = 1'b0;

        // Flush after the 5th granted byte.
        gcount = 0;
        seen0 = resp_seen;
        issue(32'h0000_0064);
        wait_grants(5);
        bus.flush = 1'b1;
        #1;
        check_eq("flush_mem_req_same_cycle", 32'(bus.mem_req), 32'd0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check_eq("flush_mem_req_after", 32'(bus.mem_req), 32'd0);
        check_eq("flush_busy_after", 32'(bus.busy), 32'd0);
        repeat (25) @(negedge clk);
        check_eq("flush_no_ready", 32'(resp_seen), 32'(seen0));
        fetch(32'h0000_0064, 19);
        check_addrs(32'h0000_0060, 16);

        // asking together with flush is dropped.
        @(negedge clk);
        bus.asking = 1'b1;
        bus.flush  = 1'b1;
        bus.addr   = 32'h0000_0000;
        @(negedge clk);
        bus.asking = 1'b0;
        bus.flush  = 1'b0;
        check_eq("ask_with_flush_busy", 32'(bus.busy), 32'd0);

        // Reset in the middle of a refill.
        gcount = 0;
        issue(32'h0000_0070);
        wait_grants(3);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("midreset");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        fetch(32'h0000_0000, 19);
        check_addrs(32'h0000_0000, 16);

        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule
